// File: rtl/stack3.sv
`default_nettype none
// ============================================================================
//  Module   : stack3
//  Purpose  : Parametrised register-file stack for the Forth CPU core, used
//             for both the data stack and the return stack. Cell 0 is the
//             top of stack (T) and cell 1 is next (N). The block tracks
//             occupancy, keeps sticky overflow/underflow flags, supports a
//             two-cell drop and has an indexed peek port.
//  Ports    : clk        - clock, all state updates on rising edge
//             resetq     - asynchronous active-low reset
//             we         - write wd into the new top cell
//             delta      - stack movement: 00=0, 01=+1, 11=-1, 10=-2
//             wd         - write data
//             clr_err    - clear ovf/unf (a new error in the same cycle wins)
//             peek_idx   - cell index for peek_data
//             rd / rd2   - cell 0 (T) / cell 1 (N)
//             peek_data  - cell[peek_idx], FILL when the index is out of range
//             count      - number of cells in use, 0..DEPTH
//             empty/full - count == 0 / count == DEPTH
//             ovf / unf  - sticky overflow / underflow
//  Revision : 1.0 - initial release
// ============================================================================
module stack3 #(
  parameter int                 DEPTH = 16,
  parameter int                 WIDTH = 16,
  parameter logic [WIDTH-1:0]   FILL  = 16'h55AA,
  localparam int                CW    = $clog2(DEPTH + 1),
  localparam int                PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              we,
  input  logic [1:0]        delta,
  input  logic [WIDTH-1:0]  wd,
  input  logic              clr_err,
  input  logic [PW-1:0]     peek_idx,
  output logic [WIDTH-1:0]  rd,
  output logic [WIDTH-1:0]  rd2,
  output logic [WIDTH-1:0]  peek_data,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam logic [1:0]    DELTA_HOLD  = 2'b00;
  localparam logic [1:0]    DELTA_PUSH  = 2'b01;
  localparam logic [1:0]    DELTA_POP2  = 2'b10;
  localparam logic [1:0]    DELTA_POP1  = 2'b11;
  localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);

  logic [WIDTH-1:0] cells_q [DEPTH];
  logic [WIDTH-1:0] cells_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Next-state logic. Cell movement never looks at count: the shift happens
  // even on an empty or full stack, count only tracks occupancy and errors.
  always_comb begin
    cells_d = cells_q;
    count_d = count_q;
    // Clear first so that an error raised below in the same cycle wins.
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;

    case (delta)
      DELTA_HOLD: begin
        if (we) cells_d[0] = wd;
      end

      DELTA_PUSH: begin
        for (int i = 1; i < DEPTH; i++) cells_d[i] = cells_q[i-1];
        // Push without a write duplicates T.
        cells_d[0] = we ? wd : cells_q[0];
        if (count_q < COUNT_FULL) count_d = count_q + CW'(1);
        else                      ovf_d   = 1'b1;
      end

      DELTA_POP1: begin
        for (int i = 0; i < DEPTH - 1; i++) cells_d[i] = cells_q[i+1];
        cells_d[DEPTH-1] = FILL;
        // Binary-op form: T' = wd, N' = old cell2.
        if (we) cells_d[0] = wd;
        if (count_q >= CW'(1)) count_d = count_q - CW'(1);
        else                   unf_d   = 1'b1;
      end

      DELTA_POP2: begin
        for (int i = 0; i < DEPTH - 2; i++) cells_d[i] = cells_q[i+2];
        cells_d[DEPTH-2] = FILL;
        cells_d[DEPTH-1] = FILL;
        // With a write, cell1 keeps the shifted old cell3.
        if (we) cells_d[0] = wd;
        if (count_q >= CW'(2)) begin
          count_d = count_q - CW'(2);
        end else begin
          count_d = '0;
          unf_d   = 1'b1;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int i = 0; i < DEPTH; i++) cells_q[i] <= FILL;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) cells_q[i] <= cells_d[i];
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Indices past the last cell can only occur for non-power-of-two DEPTH.
  always_comb begin
    peek_data = FILL;
    if (int'(peek_idx) < DEPTH) peek_data = cells_q[peek_idx];
  end

  assign rd    = cells_q[0];
  assign rd2   = cells_q[1];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_FULL);
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_stack3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack3
//  Purpose  : Directed self-checking bench for stack3 (DEPTH=16, WIDTH=16,
//             FILL=16'h55AA). Expected values are hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack3;

  localparam int          DEPTH = 16;
  localparam int          WIDTH = 16;
  localparam logic [15:0] FILL  = 16'h55AA;

  logic              clk;
  logic              resetq;
  logic              we;
  logic [1:0]        delta;
  logic [WIDTH-1:0]  wd;
  logic              clr_err;
  logic [3:0]        peek_idx;
  logic [WIDTH-1:0]  rd;
  logic [WIDTH-1:0]  rd2;
  logic [WIDTH-1:0]  peek_data;
  logic [4:0]        count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              unf;

  int n_checks;
  int n_errors;

  stack3 #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .FILL  (FILL)
  ) u_dut (
    .clk       (clk),
    .resetq    (resetq),
    .we        (we),
    .delta     (delta),
    .wd        (wd),
    .clr_err   (clr_err),
    .peek_idx  (peek_idx),
    .rd        (rd),
    .rd2       (rd2),
    .peek_data (peek_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clocked operation; outputs are stable #1 after the edge.
  task automatic op(input logic w, input logic [1:0] d, input logic [15:0] data,
                    input logic clr);
    we      = w;
    delta   = d;
    wd      = data;
    clr_err = clr;
    @(posedge clk);
    #1;
    we      = 1'b0;
    delta   = 2'b00;
    wd      = '0;
    clr_err = 1'b0;
  endtask

  // Asynchronous reset between edges, checked before any edge occurs.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    resetq = 1'b0;
    #1;
    check({tag, "_rd"},    32'(rd),        32'(FILL));
    check({tag, "_rd2"},   32'(rd2),       32'(FILL));
    check({tag, "_cnt"},   32'(count),     32'd0);
    check({tag, "_empty"}, 32'(empty),     32'd1);
    check({tag, "_flags"}, {30'd0, ovf, unf}, 32'd0);
    @(negedge clk);
    resetq = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetq   = 1'b1;
    we       = 1'b0;
    delta    = 2'b00;
    wd       = '0;
    clr_err  = 1'b0;
    peek_idx = '0;

    // Power-on reset
    #3 resetq = 1'b0;
    #1;
    check("por_rd",   32'(rd), 32'(FILL));
    check("por_peek", 32'(peek_data), 32'(FILL));
    check("por_full", 32'(full), 32'd0);
    @(negedge clk);
    resetq = 1'b1;

    // Push and pop order
    op(1'b1, 2'b01, 16'd1, 1'b0);
    op(1'b1, 2'b01, 16'd2, 1'b0);
    op(1'b1, 2'b01, 16'd3, 1'b0);
    peek_idx = 4'd2;
    #1;
    check("push_rd",   32'(rd),        32'd3);
    check("push_rd2",  32'(rd2),       32'd2);
    check("push_cnt",  32'(count),     32'd3);
    check("push_peek", 32'(peek_data), 32'd1);
    op(1'b0, 2'b11, 16'd0, 1'b0);
    check("pop_rd",  32'(rd),    32'd2);
    check("pop_cnt", 32'(count), 32'd2);
    op(1'b1, 2'b11, 16'd9, 1'b0);
    check("binop_rd",  32'(rd),    32'd9);
    check("binop_rd2", 32'(rd2),   32'(FILL));
    check("binop_cnt", 32'(count), 32'd1);

    // Reset in the middle of a sequence
    do_reset("rst_mid");

    // Drop 2
    op(1'b1, 2'b01, 16'd10, 1'b0);
    op(1'b1, 2'b01, 16'd20, 1'b0);
    op(1'b1, 2'b01, 16'd30, 1'b0);
    op(1'b1, 2'b01, 16'd40, 1'b0);
    op(1'b0, 2'b10, 16'd0, 1'b0);
    check("drop2_rd",  32'(rd),    32'd20);
    check("drop2_rd2", 32'(rd2),   32'd10);
    check("drop2_cnt", 32'(count), 32'd2);
    op(1'b1, 2'b10, 16'd7, 1'b0);
    check("drop2w_rd",  32'(rd),    32'd7);
    check("drop2w_rd2", 32'(rd2),   32'(FILL));
    check("drop2w_cnt", 32'(count), 32'd0);
    check("drop2w_unf", 32'(unf),   32'd0);
    check("drop2w_emp", 32'(empty), 32'd1);

    // Overflow
    do_reset("rst_ovf");
    for (int i = 1; i <= DEPTH + 1; i++) begin
      op(1'b1, 2'b01, 16'(i), 1'b0);
      if (i == DEPTH) check("ovf_not_yet", 32'(ovf), 32'd0);
    end
    peek_idx = 4'd15;
    #1;
    check("ovf_full", 32'(full),      32'd1);
    check("ovf_cnt",  32'(count),     32'd16);
    check("ovf_flag", 32'(ovf),       32'd1);
    check("ovf_rd",   32'(rd),        32'd17);
    check("ovf_peek", 32'(peek_data), 32'd2);
    op(1'b0, 2'b00, 16'd0, 1'b1);
    check("ovf_clr",     32'(ovf),   32'd0);
    check("ovf_clr_cnt", 32'(count), 32'd16);

    // Underflow and set-wins
    do_reset("rst_unf");
    op(1'b0, 2'b11, 16'd0, 1'b0);
    check("unf_flag", 32'(unf),   32'd1);
    check("unf_cnt",  32'(count), 32'd0);
    op(1'b0, 2'b11, 16'd0, 1'b1);
    check("unf_setwins", 32'(unf), 32'd1);
    op(1'b0, 2'b00, 16'd0, 1'b1);
    check("unf_clr", 32'(unf), 32'd0);
    // Drop 2 with a single cell in use clamps count to 0 and flags
    op(1'b1, 2'b01, 16'h1234, 1'b0);
    op(1'b0, 2'b10, 16'd0, 1'b0);
    check("unf2_cnt",  32'(count), 32'd0);
    check("unf2_flag", 32'(unf),   32'd1);
    check("unf2_ovf",  32'(ovf),   32'd0);

    // Hold and overwrite
    do_reset("rst_hold");
    op(1'b1, 2'b01, 16'd1, 1'b0);
    op(1'b1, 2'b01, 16'd2, 1'b0);
    op(1'b1, 2'b01, 16'd3, 1'b0);
    op(1'b1, 2'b00, 16'hBEEF, 1'b0);
    check("ovw_rd",  32'(rd),    32'hBEEF);
    check("ovw_rd2", 32'(rd2),   32'd2);
    check("ovw_cnt", 32'(count), 32'd3);
    op(1'b0, 2'b00, 16'hFFFF, 1'b0);
    check("hold_rd",  32'(rd),    32'hBEEF);
    check("hold_rd2", 32'(rd2),   32'd2);
    check("hold_cnt", 32'(count), 32'd3);
    // Push without write duplicates T
    op(1'b0, 2'b01, 16'h0000, 1'b0);
    check("dup_rd",  32'(rd),    32'hBEEF);
    check("dup_rd2", 32'(rd2),   32'hBEEF);
    check("dup_cnt", 32'(count), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
